decoder_3to8: RTL and testbench

Binary-to-one-hot line decoder: a 3-bit select code drives exactly one of eight output lines. It is used inside the 16-bit processor for register-file write select and other address/opcode line selection. The decode path is purely combinational. A clocked side path adds a registered copy of the decode and an optional sticky code-coverage record.

---
 rtl/decoder_3to8.sv | 50 +++++
 tb/tb_decoder_3to8.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/decoder_3to8.sv
// 3-to-8 one-hot decoder: D combinational (0 cycles), D_q registered (1 cycle), no backpressure.
// Optional sticky code coverage (seen/all_seen) compiled in with DECODER3TO8_COVERAGE_EN.
module decoder_3to8 #(
    parameter int unsigned OUT_ACTIVE_LOW = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] A,
    output logic [7:0] D,
    output logic [7:0] D_q,
    output logic [7:0] seen,
    output logic       all_seen
);

    localparam logic [7:0] ONE_HOT_BASE = 8'h01;
    localparam logic [7:0] IDLE_LEVEL   = (OUT_ACTIVE_LOW != 0) ? 8'hFF : 8'h00;

    logic [7:0] dec_hi;

    // A shift keeps an unknown select visible as X instead of silently decoding to zero.
    assign dec_hi = ONE_HOT_BASE << A;
    assign D      = (OUT_ACTIVE_LOW != 0) ? ~dec_hi : dec_hi;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            D_q <= IDLE_LEVEL;
        end else begin
            D_q <= D;
        end
    end

`ifdef DECODER3TO8_COVERAGE_EN
    logic [7:0] seen_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            seen_q <= 8'h00;
        end else begin
            seen_q <= seen_q | dec_hi;
        end
    end

    assign seen = seen_q;
`else
    assign seen = 8'h00;
`endif

    assign all_seen = &seen;

endmodule

// File: tb/tb_decoder_3to8.sv
// Directed bench for decoder_3to8: active-high and active-low instances share stimulus.
module tb_decoder_3to8;

`ifdef DECODER3TO8_COVERAGE_EN
    localparam bit COV = 1'b1;
`else
    localparam bit COV = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] A;
    logic [7:0] D, D_q, seen;
    logic       all_seen;
    logic [7:0] d_al, d_q_al, seen_al;
    logic       all_seen_al;

    int checks = 0;
    int errors = 0;

    logic [7:0] exp_sweep [8] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};
    logic [7:0] exp_sweep_al [8] = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F};

    always #10 clk = ~clk;

    decoder_3to8 #(.OUT_ACTIVE_LOW(0)) dut (
        .clk(clk), .rst_n(rst_n), .A(A),
        .D(D), .D_q(D_q), .seen(seen), .all_seen(all_seen)
    );

    decoder_3to8 #(.OUT_ACTIVE_LOW(1)) dut_al (
        .clk(clk), .rst_n(rst_n), .A(A),
        .D(d_al), .D_q(d_q_al), .seen(seen_al), .all_seen(all_seen_al)
    );

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        A     = 3'd7;
        #1;
        check("d_comb_in_reset", D, 8'h80);
        tick();
        check("rst_d_q", D_q, 8'h00);
        check("rst_d_q_al", d_q_al, 8'hFF);
        check("rst_seen", seen, 8'h00);
        check("rst_all_seen", {7'd0, all_seen}, 8'h00);
        check("rst_seen_al", seen_al, 8'h00);
        check("rst_d_held", D, 8'h80);

        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            A = 3'(i);
            #1;
            check($sformatf("sweep_d_%0d", i), D, exp_sweep[i]);
            check($sformatf("sweep_onehot_%0d", i), 8'($countones(D)), 8'd1);
            check($sformatf("sweep_d_al_%0d", i), d_al, exp_sweep_al[i]);
            tick();
            check($sformatf("sweep_d_q_%0d", i), D_q, exp_sweep[i]);
            check($sformatf("sweep_d_q_al_%0d", i), d_q_al, exp_sweep_al[i]);
        end
        check("sweep_seen", seen, COV ? 8'hFF : 8'h00);
        check("sweep_all_seen", {7'd0, all_seen}, {7'd0, COV});

        A = 3'd3;
        tick();
        A = 3'd6;
        #1;
        check("lat_d_now", D, 8'h40);
        check("lat_d_q_old", D_q, 8'h08);
        tick();
        check("lat_d_q_new", D_q, 8'h40);

        A = 3'd1;
        #5;
        A = 3'd5;
        tick();
        check("midcycle_d_q", D_q, 8'h20);

        rst_n = 1'b0;
        A     = 3'd7;
        #1;
        check("rst_no_edge_d_q", D_q, 8'h20);
        check("rst_no_edge_seen", seen, COV ? 8'hFF : 8'h00);
        check("rst2_d", D, 8'h80);
        tick();
        check("rst2_d_q", D_q, 8'h00);
        check("rst2_d_q_al", d_q_al, 8'hFF);
        check("rst2_seen", seen, 8'h00);
        check("rst2_all_seen", {7'd0, all_seen}, 8'h00);
        check("rst2_d", D, 8'h80);

        rst_n = 1'b1;
        A = 3'd0; tick();
        A = 3'd2; tick();
        A = 3'd4; tick();
        check("cov_seen_15", seen, COV ? 8'h15 : 8'h00);
        check("cov_all_seen_0", {7'd0, all_seen}, 8'h00);
        A = 3'd1; tick();
        A = 3'd3; tick();
        A = 3'd5; tick();
        A = 3'd6; tick();
        check("cov_seen_7f", seen, COV ? 8'h7F : 8'h00);
        check("cov_all_seen_pre", {7'd0, all_seen}, 8'h00);
        A = 3'd7; tick();
        check("cov_seen_ff", seen, COV ? 8'hFF : 8'h00);
        check("cov_all_seen_1", {7'd0, all_seen}, {7'd0, COV});
        check("cov_seen_al_ff", seen_al, COV ? 8'hFF : 8'h00);
        rst_n = 1'b0;
        tick();
        check("cov_rst_seen", seen, 8'h00);
        check("cov_rst_all_seen", {7'd0, all_seen}, 8'h00);

        rst_n = 1'b1;
        A = 3'd2;
        #1;
        check("al_d", d_al, 8'hFB);
        tick();
        check("al_d_q", d_q_al, 8'hFB);
        check("al_seen_first", seen, COV ? 8'h04 : 8'h00);
        rst_n = 1'b0;
        tick();
        check("al_rst_d_q", d_q_al, 8'hFF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
